// File: rtl/switch_output_scheduler.sv
// Per-output round-robin scheduler for the 8x8 router crossbar.
// Each output locks onto one input for a whole packet and releases on EOP or when its owner sits empty too long.
module switch_output_scheduler #(
  parameter int N_PORTS = 8,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         req_valid,
  input  logic [N_PORTS*SEL_W-1:0]   req_dest,
  input  logic [N_PORTS-1:0]         req_eop,
  input  logic [N_PORTS-1:0]         out_ready,
  output logic [N_PORTS-1:0]         in_pop,
  output logic [N_PORTS-1:0]         out_valid,
  output logic [N_PORTS*SEL_W-1:0]   out_sel,
  output logic [N_PORTS-1:0]         out_busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam bit              WD_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [N_PORTS-1:0]              locked;
  logic [N_PORTS-1:0][N_PORTS-1:0] pop_mat;

  // An input already owned by some output must be invisible to every arbiter,
  // which keeps each in_pop bit driven by at most one output.
  always_comb begin
    locked = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (out_busy[o] && (out_sel[o*SEL_W +: SEL_W] == SEL_W'(i))) begin
          locked[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_pop = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      in_pop = in_pop | pop_mat[o];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_out
      state_e             state_q, state_d;
      logic [SEL_W-1:0]   owner_q, owner_d;
      logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
      logic [TO_W-1:0]    wd_q, wd_d;
      logic [SEL_W-1:0]   winner;
      logic [N_PORTS-1:0] cand;
      logic [N_PORTS-1:0] pop_row;
      logic               found;
      logic               owner_avail;
      logic               xfer;
      logic               release_eop;
      logic               release_wd;

      always_comb begin
        cand = '0;
        for (int i = 0; i < N_PORTS; i++) begin
          cand[i] = req_valid[i] && !locked[i] &&
                    (req_dest[i*SEL_W +: SEL_W] == SEL_W'(gi));
        end
      end

      // First candidate at or after rr_ptr, wrapping modulo the port count.
      always_comb begin : rr_scan
        logic [SEL_W-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < N_PORTS; k++) begin
          idx = rr_ptr_q + SEL_W'(k);
          if (!found && cand[idx]) begin
            found  = 1'b1;
            winner = idx;
          end
        end
      end

      assign owner_avail = (state_q == BUSY) && req_valid[owner_q];
      assign xfer        = owner_avail && out_ready[gi] && !reset;
      assign release_eop = xfer && req_eop[owner_q];
      assign release_wd  = WD_EN && (state_q == BUSY) && !req_valid[owner_q] &&
                           (wd_q == WD_LAST);

      always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wd_d     = '0;
        case (state_q)
          IDLE: begin
            if (found) begin
              state_d = BUSY;
              owner_d = winner;
            end
          end
          BUSY: begin
            if (release_eop || release_wd) begin
              state_d  = IDLE;
              rr_ptr_d = owner_q + SEL_W'(1);
            end else if (WD_EN && !req_valid[owner_q]) begin
              // Only owner-empty cycles age the lock; ready stalls do not.
              wd_d = wd_q + TO_W'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          state_q  <= IDLE;
          owner_q  <= '0;
          rr_ptr_q <= '0;
          wd_q     <= '0;
        end else begin
          state_q  <= state_d;
          owner_q  <= owner_d;
          rr_ptr_q <= rr_ptr_d;
          wd_q     <= wd_d;
        end
      end

      always_comb begin
        pop_row = '0;
        for (int i = 0; i < N_PORTS; i++) begin
          pop_row[i] = xfer && (owner_q == SEL_W'(i));
        end
      end

      assign pop_mat[gi]                   = pop_row;
      assign out_sel[gi*SEL_W +: SEL_W]    = owner_q;
      assign out_busy[gi]                  = (state_q == BUSY);
      assign out_valid[gi]                 = owner_avail && !reset;
    end
  endgenerate

endmodule

// File: tb/tb_switch_output_scheduler.sv
// Bench for switch_output_scheduler: directed scenarios plus randomized packet traffic,
// all checked every cycle against a queue-free behavioural model of the output locks.
module tb_switch_output_scheduler;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req_valid, req_eop, out_ready;
  logic [23:0] req_dest;
  logic [7:0]  in_pop, out_valid, out_busy;
  logic [23:0] out_sel;

  always #5 clk = ~clk;

  switch_output_scheduler #(.N_PORTS(8), .SEL_W(3), .TIMEOUT(TO), .TO_W(8)) dut (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_dest(req_dest),
    .req_eop(req_eop), .out_ready(out_ready), .in_pop(in_pop),
    .out_valid(out_valid), .out_sel(out_sel), .out_busy(out_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Input sources: remaining words of the current packet and its destination.
  int src_left [8];
  int src_dest [8];
  int src_stall[8];
  bit src_hold [8];
  bit src_gap  [8];
  bit src_auto [8];
  bit rand_mode = 0;

  always_comb begin
    req_valid = '0;
    req_eop   = '0;
    req_dest  = '0;
    for (int i = 0; i < 8; i++) begin
      req_valid[i]       = (src_left[i] > 0) && !src_hold[i] && !src_gap[i];
      req_eop[i]         = (src_left[i] == 1);
      req_dest[i*3 +: 3] = src_dest[i][2:0];
    end
  end

  // Model: owner per output (-1 = free), last owner shown on out_sel, pointer, empty count.
  int m_own[8] = '{default: -1};
  int m_sel[8] = '{default: 0};
  int m_ptr[8] = '{default: 0};
  int m_cnt[8] = '{default: 0};
  int n_own[8] = '{default: -1};
  int n_sel[8] = '{default: 0};
  int n_ptr[8] = '{default: 0};
  int n_cnt[8] = '{default: 0};
  logic [7:0]  e_pop, e_valid, e_busy, pop_seen = '0;
  logic [23:0] e_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit owned(int i);
    for (int x = 0; x < 8; x++) if (m_own[x] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick(int o);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (m_ptr[o] + k) % 8;
      if (req_valid[i] && int'(req_dest[i*3 +: 3]) == o && !owned(i)) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    e_pop = '0; e_valid = '0; e_busy = '0; e_sel = '0;
    for (int o = 0; o < 8; o++) begin
      e_sel[o*3 +: 3] = m_sel[o][2:0];
      if (m_own[o] >= 0) begin
        e_busy[o] = 1'b1;
        if (!reset && req_valid[m_own[o]]) e_valid[o] = 1'b1;
        if (e_valid[o] && out_ready[o]) e_pop[m_own[o]] = 1'b1;
      end
    end
    check("cmp_in_pop",    32'(in_pop),    32'(e_pop));
    check("cmp_out_valid", 32'(out_valid), 32'(e_valid));
    check("cmp_out_busy",  32'(out_busy),  32'(e_busy));
    check("cmp_out_sel",   32'(out_sel),   32'(e_sel));
    pop_seen = e_pop;
    for (int o = 0; o < 8; o++) begin
      n_own[o] = m_own[o]; n_sel[o] = m_sel[o]; n_ptr[o] = m_ptr[o]; n_cnt[o] = m_cnt[o];
      if (reset) begin
        n_own[o] = -1; n_sel[o] = 0; n_ptr[o] = 0; n_cnt[o] = 0;
      end else if (m_own[o] >= 0) begin
        w = m_own[o];
        if (e_pop[w] && req_eop[w]) begin
          n_own[o] = -1; n_ptr[o] = (w + 1) % 8; n_cnt[o] = 0;
        end else if (req_valid[w]) begin
          n_cnt[o] = 0;
        end else begin
          n_cnt[o] = m_cnt[o] + 1;
          if (TO > 0 && n_cnt[o] >= TO) begin
            n_own[o] = -1; n_ptr[o] = (w + 1) % 8; n_cnt[o] = 0;
          end
        end
      end else begin
        n_cnt[o] = 0;
        w = pick(o);
        if (w >= 0) begin
          n_own[o] = w; n_sel[o] = w;
        end
      end
    end
  end

  // Every rising edge passes through here: commit the model, then advance the sources.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int o = 0; o < 8; o++) begin
      m_own[o] = n_own[o]; m_sel[o] = n_sel[o]; m_ptr[o] = n_ptr[o]; m_cnt[o] = n_cnt[o];
    end
    for (int i = 0; i < 8; i++) begin
      if (pop_seen[i] && src_left[i] > 0) begin
        src_left[i]--;
        if (src_left[i] == 0 && src_auto[i]) src_left[i] = 1;
      end
      if (rand_mode) begin
        if (src_stall[i] > 0) src_stall[i]--;
        else if (src_left[i] > 0 && $urandom_range(0, 19) == 0) src_stall[i] = $urandom_range(2, 7);
        src_gap[i] = (src_stall[i] > 0) || ($urandom_range(0, 5) == 0);
        if (src_left[i] == 0 && $urandom_range(0, 2) == 0) begin
          src_left[i] = $urandom_range(1, 4);
          src_dest[i] = $urandom_range(0, 7);
        end
      end
    end
    #1;
  endtask

  task automatic start_pkt(input int i, input int d, input int len);
    src_left[i] = len; src_dest[i] = d; src_hold[i] = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 8; i++) begin
      src_left[i] = 0; src_hold[i] = 0; src_gap[i] = 0; src_stall[i] = 0; src_auto[i] = 0;
    end
    out_ready = 8'hFF;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [23:0] sel_exp;
    int rr_exp[6] = '{0, 3, 7, 0, 3, 7};
    int got[$];
    logic prev_b;

    // Reset with every input requesting.
    out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) start_pkt(i, i, 2);
    tick();
    tick();
    @(negedge clk);
    check("rst_in_pop", 32'(in_pop), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_busy", 32'(out_busy), 0);
    check("rst_out_sel", 32'(out_sel), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_arb_busy", 32'(out_busy), 0);
    tick();
    @(negedge clk);
    sel_exp = '0;
    for (int o = 0; o < 8; o++) sel_exp[o*3 +: 3] = 3'(o);
    check("rst_first_grant_busy", 32'(out_busy), 32'hFF);
    check("rst_first_grant_sel", 32'(out_sel), 32'(sel_exp));

    // Single 3-word packet, input 2 -> output 5.
    do_reset();
    start_pkt(2, 5, 3);
    @(negedge clk);
    check("single_arb_busy5", 32'(out_busy[5]), 0);
    check("single_arb_pop", 32'(in_pop), 0);
    tick();
    @(negedge clk);
    check("single_busy5", 32'(out_busy[5]), 1);
    check("single_sel5", 32'(out_sel[17:15]), 2);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      $display("single: word %0d pop=%02h", k, in_pop);
      check("single_pop2", 32'(in_pop), 32'h04);
    end
    tick();
    @(negedge clk);
    check("single_released", 32'(out_busy[5]), 0);
    check("single_model_ptr5", 32'(m_ptr[5]), 3);

    // Round-robin among inputs 0, 3, 7 sending 1-word packets to output 1.
    do_reset();
    start_pkt(0, 1, 1); start_pkt(3, 1, 1); start_pkt(7, 1, 1);
    src_auto[0] = 1; src_auto[3] = 1; src_auto[7] = 1;
    prev_b = 1'b0;
    for (int c = 0; c < 80 && got.size() < 6; c++) begin
      @(negedge clk);
      if (out_busy[1] && !prev_b) begin
        got.push_back(int'(out_sel[5:3]));
        $display("rr: grant %0d -> input %0d", got.size(), out_sel[5:3]);
      end
      prev_b = out_busy[1];
      tick();
    end
    check("rr_grant_count", 32'(got.size()), 6);
    for (int k = 0; k < got.size() && k < 6; k++) check("rr_order", 32'(got[k]), 32'(rr_exp[k]));

    // Lock with ready stalls: input 4 owns output 0, input 6 waits.
    do_reset();
    start_pkt(4, 0, 4);
    @(negedge clk);
    check("lock_arb_busy0", 32'(out_busy[0]), 0);
    tick();
    @(negedge clk);
    check("lock_sel0", 32'(out_sel[2:0]), 4);
    check("lock_first_pop", 32'(in_pop), 32'h10);
    tick();
    start_pkt(6, 0, 2);
    for (int c = 0; c < 30 && src_left[4] != 0; c++) begin
      out_ready = {7'h7F, 1'(c % 2)};
      @(negedge clk);
      $display("lock: ready0=%0d pop=%02h sel0=%0d", out_ready[0], in_pop, out_sel[2:0]);
      check("lock_sel_held", 32'(out_sel[2:0]), 4);
      check("lock_no_pop6", 32'(in_pop[6]), 0);
      check("lock_pop4_on_ready", 32'(in_pop[4]), 32'(c % 2));
      tick();
    end
    check("lock_packet_done", 32'(src_left[4]), 0);
    out_ready = 8'hFF;
    @(negedge clk);
    check("lock_rearb_busy0", 32'(out_busy[0]), 0);
    tick();
    @(negedge clk);
    check("lock_next_owner", 32'(out_sel[2:0]), 6);

    // All eight outputs granted on the same edge.
    do_reset();
    for (int i = 0; i < 8; i++) start_pkt(i, 7 - i, 2);
    @(negedge clk);
    check("par_arb_busy", 32'(out_busy), 0);
    tick();
    @(negedge clk);
    sel_exp = '0;
    for (int o = 0; o < 8; o++) sel_exp[o*3 +: 3] = 3'(7 - o);
    check("par_busy", 32'(out_busy), 32'hFF);
    check("par_pop", 32'(in_pop), 32'hFF);
    check("par_sel", 32'(out_sel), 32'(sel_exp));

    // Watchdog: owner 1 of output 2 goes empty; input 5 is waiting.
    do_reset();
    start_pkt(1, 2, 3);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("wd_busy2", 32'(out_busy[2]), 1);
    check("wd_pop1", 32'(in_pop), 32'h02);
    tick();
    src_hold[1] = 1;
    start_pkt(5, 2, 1);
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check("wd_hold_busy", 32'(out_busy[2]), 1);
      check("wd_hold_nopop", 32'(in_pop), 0);
      tick();
    end
    @(negedge clk);
    check("wd_released", 32'(out_busy[2]), 0);
    check("wd_model_ptr2", 32'(m_ptr[2]), 2);
    tick();
    @(negedge clk);
    check("wd_regrant_sel", 32'(out_sel[8:6]), 5);
    check("wd_regrant_pop", 32'(in_pop), 32'h20);

    // Reset in the middle of two packets.
    do_reset();
    start_pkt(0, 3, 5);
    start_pkt(2, 6, 5);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("mrst_busy", 32'(out_busy), 32'h48);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mrst_pop_forced", 32'(in_pop), 0);
    check("mrst_valid_forced", 32'(out_valid), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mrst_idle", 32'(out_busy), 0);

    // Randomized traffic with ready stalls, owner stalls and rare resets.
    do_reset();
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      for (int o = 0; o < 8; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    rand_mode = 0;
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
